// File: rtl/branch_resolve_bht_if.sv
// Fetch-lookup and EX-resolve signal bundle for branch_resolve_bht.
// master = pipeline side, slave = branch resolver / BHT.
interface branch_resolve_bht_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic            res_valid;
  logic            res_kill;
  logic [XLEN-1:0] res_pc;
  logic [2:0]      res_funct3;
  logic [XLEN-1:0] res_rs1;
  logic [XLEN-1:0] res_rs2;
  logic            res_pred_taken;
  logic [XLEN-1:0] res_target;
  logic [XLEN-1:0] res_fallthrough;
  logic            branch_taken;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            illegal;

  modport master (
    output pred_pc, res_valid, res_kill, res_pc, res_funct3, res_rs1, res_rs2,
           res_pred_taken, res_target, res_fallthrough,
    input  pred_taken, branch_taken, redirect, redirect_pc, illegal
  );

  modport slave (
    input  pred_pc, res_valid, res_kill, res_pc, res_funct3, res_rs1, res_rs2,
           res_pred_taken, res_target, res_fallthrough,
    output pred_taken, branch_taken, redirect, redirect_pc, illegal
  );
endinterface

// File: rtl/branch_resolve_bht.sv
// Branch resolver with direct-mapped 2-bit-counter BHT; combinational lookup, redirect registered 1 cycle after resolve.
// Always ready, no backpressure. Optional counters under macro BRANCH_STATS_EN.
module branch_resolve_bht #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_bht_if.slave   bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]      r_bht [BHT_DEPTH];
  logic            r_branch_taken;
  logic            r_redirect;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_illegal;

  logic [IDX_W-1:0] w_pred_idx;
  logic [IDX_W-1:0] w_res_idx;
  logic             w_taken;
  logic             w_accept;
  logic             w_illegal;
  logic             w_update;
  logic             w_mispredict;
  logic             w_unused_pc_bits;

  assign w_pred_idx = bus.pred_pc[IDX_W+1:2];
  assign w_res_idx  = bus.res_pc[IDX_W+1:2];
  assign w_unused_pc_bits = ^{bus.pred_pc[XLEN-1:IDX_W+2], bus.pred_pc[1:0],
                              bus.res_pc[XLEN-1:IDX_W+2], bus.res_pc[1:0]};

  // No bypass: a same-cycle update becomes visible on the next cycle.
  assign bus.pred_taken = r_bht[w_pred_idx][1];

  always_comb begin
    w_taken = 1'b0;
    case (bus.res_funct3)
      3'b000:  w_taken = (bus.res_rs1 == bus.res_rs2);
      3'b001:  w_taken = (bus.res_rs1 != bus.res_rs2);
      3'b100:  w_taken = ($signed(bus.res_rs1) <  $signed(bus.res_rs2));
      3'b101:  w_taken = ($signed(bus.res_rs1) >= $signed(bus.res_rs2));
      3'b110:  w_taken = (bus.res_rs1 <  bus.res_rs2);
      3'b111:  w_taken = (bus.res_rs1 >= bus.res_rs2);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_accept     = bus.res_valid & ~bus.res_kill;
  assign w_illegal    = (bus.res_funct3[2:1] == 2'b01);
  assign w_update     = w_accept & ~w_illegal;
  assign w_mispredict = w_taken != bus.res_pred_taken;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_bht[i] <= CTR_INIT;
      end
      r_branch_taken <= 1'b0;
      r_redirect     <= 1'b0;
      r_redirect_pc  <= '0;
      r_illegal      <= 1'b0;
    end else begin
      r_branch_taken <= w_update & w_taken;
      r_redirect     <= w_update & w_mispredict;
      r_illegal      <= w_accept & w_illegal;
      if (w_update) begin
        r_redirect_pc <= w_taken ? bus.res_target : bus.res_fallthrough;
        if (w_taken && (r_bht[w_res_idx] != 2'b11)) begin
          r_bht[w_res_idx] <= r_bht[w_res_idx] + 2'd1;
        end else if (!w_taken && (r_bht[w_res_idx] != 2'b00)) begin
          r_bht[w_res_idx] <= r_bht[w_res_idx] - 2'd1;
        end
      end
    end
  end

  assign bus.branch_taken = r_branch_taken;
  assign bus.redirect     = r_redirect;
  assign bus.redirect_pc  = r_redirect_pc;
  assign bus.illegal      = r_illegal;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_update) begin
      r_stat_branches <= r_stat_branches + 32'd1;
      if (w_mispredict) begin
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      end
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Self-checking bench for branch_resolve_bht: directed scenarios plus randomized resolves against a reference model.
module tb_branch_resolve_bht;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_bht_if #(.XLEN(32)) bus ();

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_b;
  logic [31:0] stat_m;
`endif

  branch_resolve_bht #(.XLEN(32), .BHT_DEPTH(64), .CTR_INIT(2'b01)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_b),
    .stat_mispredicts (stat_m)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: counter values as plain integers 0..3, expected registered outputs.
  int unsigned m_ctr [64];
  bit          e_bt, e_rd, e_ill;
  logic [31:0] e_rpc;
  int unsigned e_sb, e_sm;

  function automatic bit model_outcome(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return longint'(a) < longint'(b);
      3'd7: return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    return m_ctr[(pc / 4) % 64] >= 2;
  endfunction

  task automatic set_res(input bit v, input bit k, input logic [31:0] pc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input bit p, input logic [31:0] tgt);
    bus.res_valid       = v;
    bus.res_kill        = k;
    bus.res_pc          = pc;
    bus.res_funct3      = f3;
    bus.res_rs1         = a;
    bus.res_rs2         = b;
    bus.res_pred_taken  = p;
    bus.res_target      = tgt;
    bus.res_fallthrough = pc + 32'd4;
  endtask

  task automatic idle();
    set_res(0, 0, 32'h0, 3'd0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  // Advance the model with the inputs present before the edge, then step one clock.
  task automatic tick();
    bit t;
    int unsigned ix;
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      e_bt = 0; e_rd = 0; e_ill = 0; e_rpc = 32'h0; e_sb = 0; e_sm = 0;
    end else if (bus.res_valid && !bus.res_kill) begin
      if (bus.res_funct3 == 3'd2 || bus.res_funct3 == 3'd3) begin
        e_ill = 1; e_bt = 0; e_rd = 0;
      end else begin
        t     = model_outcome(bus.res_funct3, bus.res_rs1, bus.res_rs2);
        ix    = (bus.res_pc / 4) % 64;
        e_bt  = t;
        e_rd  = (t != bus.res_pred_taken);
        e_rpc = t ? bus.res_target : bus.res_fallthrough;
        e_ill = 0;
        if (t) m_ctr[ix] = (m_ctr[ix] == 3) ? 3 : m_ctr[ix] + 1;
        else   m_ctr[ix] = (m_ctr[ix] == 0) ? 0 : m_ctr[ix] - 1;
        e_sb++;
        if (e_rd) e_sm++;
      end
    end else begin
      e_bt = 0; e_rd = 0; e_ill = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] pcs [3];
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h13C;
    rst_n = 1'b0;
    idle();
    bus.pred_pc = 32'h0;
    tick();
    tick();
    n_vec++; if (bus.redirect !== 1'b0 || bus.branch_taken !== 1'b0 || bus.illegal !== 1'b0) begin
      n_err++; $display("FAIL reset_flags got rd=%b bt=%b ill=%b want 0 0 0", bus.redirect, bus.branch_taken, bus.illegal);
    end
    n_vec++; if (bus.redirect_pc !== 32'h0) begin
      n_err++; $display("FAIL reset_redirect_pc got=%h want=0", bus.redirect_pc);
    end
    rst_n = 1'b1;
    foreach (pcs[i]) begin
      bus.pred_pc = pcs[i];
      #1;
      n_vec++; if (bus.pred_taken !== 1'b0) begin
        n_err++; $display("FAIL reset_pred pc=%h got=%b want=0", pcs[i], bus.pred_taken);
      end
    end
    tick();
    n_vec++; if (bus.redirect !== 1'b0 || bus.branch_taken !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle got rd=%b bt=%b want 0 0", bus.redirect, bus.branch_taken);
    end
  endtask

  task automatic test_beq_taken();
    set_res(1, 0, 32'h40, 3'd0, 32'd5, 32'd5, 0, 32'h80);
    tick();
    idle();
    n_vec++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h80 || bus.branch_taken !== 1'b1) begin
      n_err++; $display("FAIL beq_taken got rd=%b pc=%h bt=%b want 1 00000080 1", bus.redirect, bus.redirect_pc, bus.branch_taken);
    end
    bus.pred_pc = 32'h40;
    #1;
    n_vec++; if (bus.pred_taken !== 1'b1) begin
      n_err++; $display("FAIL beq_pred_after got=%b want=1", bus.pred_taken);
    end
    tick();
    n_vec++; if (bus.redirect !== 1'b0) begin
      n_err++; $display("FAIL redirect_pulse got=%b want=0", bus.redirect);
    end
  endtask

  task automatic test_signed_unsigned();
    set_res(1, 0, 32'h208, 3'd4, 32'hFFFF_FFFF, 32'd1, 1, 32'h300);
    tick();
    n_vec++; if (bus.branch_taken !== 1'b1 || bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h300) begin
      n_err++; $display("FAIL blt_signed got bt=%b rd=%b pc=%h want 1 0 00000300", bus.branch_taken, bus.redirect, bus.redirect_pc);
    end
    set_res(1, 0, 32'h208, 3'd6, 32'hFFFF_FFFF, 32'd1, 1, 32'h300);
    tick();
    idle();
    n_vec++; if (bus.branch_taken !== 1'b0 || bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h20C) begin
      n_err++; $display("FAIL bltu_unsigned got bt=%b rd=%b pc=%h want 0 1 0000020c", bus.branch_taken, bus.redirect, bus.redirect_pc);
    end
    tick();
  endtask

  task automatic test_saturation();
    bit want [7];
    want = '{1, 1, 1, 1, 1, 1, 0};
    bus.pred_pc = 32'h100;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) set_res(1, 0, 32'h100, 3'd0, 32'd7, 32'd7, 1, 32'h400);
      else       set_res(1, 0, 32'h100, 3'd0, 32'd7, 32'd8, 1, 32'h400);
      tick();
      #1;
      n_vec++; if (bus.pred_taken !== want[i]) begin
        n_err++; $display("FAIL saturation step=%0d got=%b want=%b", i, bus.pred_taken, want[i]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_kill_illegal();
    set_res(1, 1, 32'h40, 3'd0, 32'd1, 32'd2, 1, 32'h80);
    tick();
    bus.pred_pc = 32'h40;
    #1;
    n_vec++; if (bus.redirect !== 1'b0 || bus.branch_taken !== 1'b0) begin
      n_err++; $display("FAIL kill_outputs got rd=%b bt=%b want 0 0", bus.redirect, bus.branch_taken);
    end
    n_vec++; if (bus.pred_taken !== 1'b1) begin
      n_err++; $display("FAIL kill_bht got=%b want=1", bus.pred_taken);
    end
    set_res(1, 0, 32'h40, 3'd2, 32'd1, 32'd2, 1, 32'h80);
    tick();
    idle();
    n_vec++; if (bus.illegal !== 1'b1 || bus.redirect !== 1'b0 || bus.branch_taken !== 1'b0) begin
      n_err++; $display("FAIL illegal got ill=%b rd=%b bt=%b want 1 0 0", bus.illegal, bus.redirect, bus.branch_taken);
    end
    n_vec++; if (bus.pred_taken !== 1'b1) begin
      n_err++; $display("FAIL illegal_bht got=%b want=1", bus.pred_taken);
    end
    tick();
    n_vec++; if (bus.illegal !== 1'b0) begin
      n_err++; $display("FAIL illegal_pulse got=%b want=0", bus.illegal);
    end
  endtask

  task automatic test_reset_override();
    rst_n = 1'b0;
    set_res(1, 0, 32'h40, 3'd0, 32'd9, 32'd9, 0, 32'h80);
    tick();
    rst_n = 1'b1;
    idle();
    bus.pred_pc = 32'h40;
    #1;
    n_vec++; if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h0) begin
      n_err++; $display("FAIL reset_override got rd=%b pc=%h want 0 00000000", bus.redirect, bus.redirect_pc);
    end
    n_vec++; if (bus.pred_taken !== 1'b0) begin
      n_err++; $display("FAIL reset_override_bht got=%b want=0", bus.pred_taken);
    end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    set_res(1, 0, 32'h300, 3'd0, 32'd4, 32'd4, 1, 32'h500);
    tick();
    set_res(1, 0, 32'h304, 3'd1, 32'd4, 32'd4, 0, 32'h500);
    tick();
    set_res(1, 0, 32'h308, 3'd7, 32'd5, 32'd3, 0, 32'h500);
    tick();
    idle();
    n_vec++; if (stat_b !== 32'd3 || stat_m !== 32'd1) begin
      n_err++; $display("FAIL stats got br=%0d mp=%0d want 3 1", stat_b, stat_m);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [31:0] pc, a, b;
    for (int n = 0; n < 400; n++) begin
      pc = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 8);
      a  = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 3);
      b  = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 3));
      set_res($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, pc, 3'($urandom_range(0, 7)),
              a, b, $urandom_range(0, 1) == 1, $urandom);
      bus.pred_pc = ($urandom_range(0, 1) == 1) ? pc : (($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 8));
      #1;
      n_vec++; if (bus.pred_taken !== model_pred(bus.pred_pc)) begin
        n_err++; $display("FAIL rnd_pred n=%0d pc=%h got=%b want=%b", n, bus.pred_pc, bus.pred_taken, model_pred(bus.pred_pc));
      end
      tick();
      n_vec++; if (bus.branch_taken !== e_bt || bus.redirect !== e_rd || bus.illegal !== e_ill || bus.redirect_pc !== e_rpc) begin
        n_err++; $display("FAIL rnd_out n=%0d got bt=%b rd=%b ill=%b pc=%h want %b %b %b %h",
                          n, bus.branch_taken, bus.redirect, bus.illegal, bus.redirect_pc, e_bt, e_rd, e_ill, e_rpc);
      end
`ifdef BRANCH_STATS_EN
      n_vec++; if (stat_b !== e_sb || stat_m !== e_sm) begin
        n_err++; $display("FAIL rnd_stats n=%0d got %0d %0d want %0d %0d", n, stat_b, stat_m, e_sb, e_sm);
      end
`endif
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_signed_unsigned();
    test_saturation();
    test_kill_illegal();
    test_reset_override();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- Parametrised successor to the single-cycle branch comparator: resolves conditional branches for any XLEN and keeps a direct-mapped branch history table (BHT) of 2-bit saturating counters.
- Fetch gets a taken/not-taken prediction each cycle. EX supplies resolved branches, and the block returns a registered mispredict redirect one cycle later.
- Sits between IF (lookup port) and EX/MEM (resolve port) of the RV32IM pipeline.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_DEPTH, 64, number of BHT entries. Must be a power of 2, minimum 2.
- CTR_INIT, 2'b01, counter value loaded into every entry on reset (weakly not-taken).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- pred_pc  in  XLEN  fetch PC to predict.
- pred_taken  out  1  combinational prediction: MSB of BHT[idx(pred_pc)].
- res_valid  in  1  a branch is resolving this cycle.
- res_kill  in  1  squash the resolve this cycle (wrong-path instruction).
- res_pc  in  XLEN  PC of the resolving branch.
- res_funct3  in  3  instruction[14:12].
- res_rs1  in  XLEN  first operand.
- res_rs2  in  XLEN  second operand.
- res_pred_taken  in  1  prediction issued for this branch at fetch.
- res_target  in  XLEN  branch target address.
- res_fallthrough  in  XLEN  res_pc+4.
- branch_taken  out  1  registered actual outcome.
- redirect  out  1  registered one-cycle mispredict pulse.
- redirect_pc  out  XLEN  registered corrected PC, meaningful while redirect=1.
- illegal  out  1  registered pulse: funct3 was 010 or 011.

Behaviour:
- Reset: when rst_n=0 at posedge, all BHT entries <= CTR_INIT; branch_taken, redirect, illegal <= 0; redirect_pc <= 0. Reset overrides any concurrent resolve.
- Index: idx(pc) = pc[log2(BHT_DEPTH)+1:2]. Upper PC bits are ignored (aliasing is allowed).
- Compare, funct3 encoding:
  - 000 eq, 001 ne
  - 100 signed lt, 101 signed ge
  - 110 unsigned lt, 111 unsigned ge
  - All comparisons use the full XLEN width.
- Accepted resolve = res_valid & ~res_kill & rst_n.
- Latency: outputs are registered at the posedge that samples an accepted resolve and are valid in the following cycle.
- When a resolve is accepted with legal funct3 (outcome t):
  - branch_taken <= t.
  - redirect <= (t != res_pred_taken).
  - redirect_pc <= t ? res_target : res_fallthrough.
  - illegal <= 0.
  - BHT[idx(res_pc)] updated: t=1 increments, saturating at 11; t=0 decrements, saturating at 00.
- When a resolve is accepted with illegal funct3 (010/011):
  - illegal <= 1, branch_taken <= 0, redirect <= 0.
  - BHT unchanged.
- No accepted resolve (res_valid=0 or res_kill=1): branch_taken, redirect, illegal <= 0. redirect_pc holds. BHT unchanged.
- redirect is a single-cycle pulse. Back-to-back accepted resolves each produce their own independent pulse.
- Same-cycle lookup and update of the same index: pred_taken returns the pre-update value (no bypass). The new value is visible from the next cycle.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds two outputs:
  - stat_branches (32 bits): counts accepted legal resolves.
  - stat_mispredicts (32 bits): counts accepted legal resolves that raised redirect.
- Both counters reset to 0 with rst_n and wrap modulo 2^32.
- When not defined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then for pred_pc=0x40, 0x44, 0x13C: pred_taken=0 (all entries = 01) -> redirect=0, branch_taken=0 in the cycle after reset release.
- BEQ rs1=rs2=5, res_pc=0x40, pred 0, target 0x80 -> next cycle redirect=1, redirect_pc=0x80, branch_taken=1; pred_taken at 0x40 is 1 afterwards (counter 10).
- Signed/unsigned split, rs1=0xFFFFFFFF, rs2=1 -> BLT taken and BLTU not taken. With pred=1 on both: BLT gives no redirect; BLTU gives redirect=1, redirect_pc=res_fallthrough.
- Saturation: five taken resolves on the same PC keep the counter at 11; two not-taken resolves bring it to 01, so the prediction flips to 0 only after the second.
- res_valid=1 with res_kill=1 and mispredicting operands -> redirect=0 and the BHT is unchanged. funct3=010 -> illegal=1 for one cycle, redirect=0.
- rst_n asserted in the same cycle as a mispredicting resolve -> next cycle redirect=0 and the entry equals CTR_INIT. With BRANCH_STATS_EN, 3 resolves including 1 mispredict give stat_branches=3, stat_mispredicts=1.
